// File: rtl/fetch_prefetch_unit_if.sv
// Fetch/decode-side and instruction-memory signals of the prefetch unit.
// The unit uses the master modport and its environment uses the slave modport.
interface fetch_prefetch_unit_if;
    logic        fetch_enable;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_address;
    logic [31:0] imem_instruction;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;

    modport master (
        input  fetch_enable,
        input  redirect_valid,
        input  redirect_pc,
        input  imem_instruction,
        input  out_ready,
        output imem_address,
        output out_valid,
        output out_instruction,
        output out_pc
    );

    modport slave (
        output fetch_enable,
        output redirect_valid,
        output redirect_pc,
        output imem_instruction,
        output out_ready,
        input  imem_address,
        input  out_valid,
        input  out_instruction,
        input  out_pc
    );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch sequencer: reads a combinational word-indexed memory at fetch_pc and
// streams {pc, instruction} pairs through a small FIFO to decode; redirects flush and restart.
module fetch_prefetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                   clk,
    input logic                   rst_n,
    fetch_prefetch_unit_if.master bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h3;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      pc_mem_q    [DEPTH];
    logic [31:0]      instr_mem_q [DEPTH];

    logic pop;
    logic push;

    always_comb begin
        pop  = (count_q != '0) && bus.out_ready;
        // A full FIFO may still accept when the head leaves in the same cycle.
        push = bus.fetch_enable && !bus.redirect_valid &&
               ((count_q < CNT_W'(DEPTH)) || pop);

        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (bus.redirect_valid) begin
            // Redirect overrides any pop offered this cycle; the old head is dropped.
            fetch_pc_d = bus.redirect_pc & ~32'h3;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC_ALIGNED;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage is cleared on reset so the head reads as zero while empty after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else if (push) begin
            pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
            instr_mem_q[wr_ptr_q] <= bus.imem_instruction;
        end
    end

    assign bus.imem_address    = {2'b00, fetch_pc_q[31:2]};
    assign bus.out_valid       = (count_q != '0);
    assign bus.out_pc          = pc_mem_q[rd_ptr_q];
    assign bus.out_instruction = instr_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed table-driven bench for fetch_prefetch_unit with a combinational memory model.
module tb_fetch_prefetch_unit;

    logic clk;
    logic rst_n;

    fetch_prefetch_unit_if bus ();

    fetch_prefetch_unit #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents are a fixed function of the word index.
    function automatic logic [31:0] mem_word(input logic [31:0] idx);
        return {idx[15:0] ^ 16'hBEEF, idx[15:0]};
    endfunction

    assign bus.imem_instruction = mem_word(bus.imem_address);

    typedef struct {
        logic        ev;
        logic [31:0] epc;
        logic [31:0] efpc;
        logic        fe;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   failures;

    task automatic add(input logic ev, input logic [31:0] epc, input logic [31:0] efpc,
                       input logic fe, input logic rv, input logic [31:0] rpc, input logic rdy);
        vec_t v;
        v.ev = ev; v.epc = epc; v.efpc = efpc;
        v.fe = fe; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic ev, input logic [31:0] epc,
                             input logic [31:0] efpc);
        chk({tag, " out_valid"}, {31'd0, bus.out_valid}, {31'd0, ev});
        chk({tag, " imem_address"}, bus.imem_address, {2'b00, efpc[31:2]});
        if (ev) begin
            chk({tag, " out_pc"}, bus.out_pc, epc);
            chk({tag, " out_instruction"}, bus.out_instruction, mem_word({2'b00, epc[31:2]}));
        end
    endtask

    task automatic drive(input logic fe, input logic rv, input logic [31:0] rpc, input logic rdy);
        bus.fetch_enable   = fe;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.out_ready      = rdy;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(1'b1, 1'b0, 32'h0, 1'b1);

        // Each row: expected outputs this cycle, then inputs applied for the coming edge.
        // Startup stream, then redirect to 0 to begin a clean stall test.
        add(0, 32'h0, 32'h0,  1, 0, 32'h0, 1);
        add(1, 32'h0, 32'h4,  1, 0, 32'h0, 1);
        add(1, 32'h4, 32'h8,  1, 0, 32'h0, 1);
        add(1, 32'h8, 32'hC,  1, 0, 32'h0, 1);
        add(1, 32'hC, 32'h10, 1, 1, 32'h0, 1);
        // Ten cycles of out_ready = 0: fills to 4, fetch_pc holds at 0x10, head stays at 0.
        add(0, 32'h0, 32'h0,  1, 0, 32'h0, 0);
        add(1, 32'h0, 32'h4,  1, 0, 32'h0, 0);
        add(1, 32'h0, 32'h8,  1, 0, 32'h0, 0);
        add(1, 32'h0, 32'hC,  1, 0, 32'h0, 0);
        for (int i = 0; i < 6; i++) add(1, 32'h0, 32'h10, 1, 0, 32'h0, 0);
        // Release: full FIFO pushes and pops together, no gap or duplicate.
        add(1, 32'h0,  32'h10, 1, 0, 32'h0, 1);
        add(1, 32'h4,  32'h14, 1, 0, 32'h0, 1);
        add(1, 32'h8,  32'h18, 1, 0, 32'h0, 1);
        add(1, 32'hC,  32'h1C, 1, 0, 32'h0, 1);
        add(1, 32'h10, 32'h20, 0, 0, 32'h0, 1);
        // Three entries held; misaligned redirect with out_ready = 1.
        add(1, 32'h14, 32'h20, 1, 1, 32'h0000_0103, 1);
        add(0, 32'h0,  32'h100, 1, 0, 32'h0, 1);
        add(1, 32'h100, 32'h104, 1, 0, 32'h0, 1);
        add(1, 32'h104, 32'h108, 1, 1, 32'hFFFF_FFF8, 1);
        // Wrap at the top of the address space.
        add(0, 32'h0,         32'hFFFF_FFF8, 1, 0, 32'h0, 1);
        add(1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 1, 0, 32'h0, 1);
        add(1, 32'hFFFF_FFFC, 32'h0,         1, 0, 32'h0, 1);
        add(1, 32'h0,         32'h4,         0, 0, 32'h0, 1);
        // fetch_enable = 0 drains and holds; redirects still apply, last one wins.
        add(0, 32'h0, 32'h4,   0, 0, 32'h0,   1);
        add(0, 32'h0, 32'h4,   0, 1, 32'h200, 1);
        add(0, 32'h0, 32'h200, 0, 1, 32'h300, 1);
        add(0, 32'h0, 32'h300, 1, 0, 32'h0,   1);
        add(1, 32'h300, 32'h304, 1, 0, 32'h0, 0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("reset out_pc", bus.out_pc, 32'h0);
        chk("reset out_instruction", bus.out_instruction, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            chk_state($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].efpc);
            drive(vecs[i].fe, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
            @(negedge clk);
        end

        // Fill to full while stalled, then pulse reset between edges.
        repeat (3) @(negedge clk);
        chk_state("full before reset", 1'b1, 32'h300, 32'h310);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset out_valid", {31'd0, bus.out_valid}, 32'h0);
        chk("async reset out_pc", bus.out_pc, 32'h0);
        chk("async reset out_instruction", bus.out_instruction, 32'h0);
        chk("async reset imem_address", bus.imem_address, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        chk_state("post reset c0", 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk_state("post reset c1", 1'b1, 32'h0, 32'h4);
        @(negedge clk);
        chk_state("post reset c2", 1'b1, 32'h4, 32'h8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
